// File: rtl/hsid_pkg.sv
// Shared types and sizing helpers for the hyperspectral distance path.
package hsid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sq_acc_state_t;

  // Width that holds (2^dw-1)^2 * (2^lb-1) without wrapping.
  function automatic int acc_width(input int dw, input int lb);
    return 2 * dw + lb;
  endfunction

endpackage

// File: rtl/hsid_sq_stage.sv
// Registered unsigned squarer, one cycle of latency, valid travels with data.
module hsid_sq_stage #(
  parameter int IN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [IN_WIDTH-1:0]   in_data_i,
  output logic                  out_valid_o,
  output logic [2*IN_WIDTH-1:0] out_data_o
);

  logic                  sq_v_q;
  logic [2*IN_WIDTH-1:0] sq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_v_q <= 1'b0;
      sq_q   <= '0;
    end else begin
      sq_v_q <= in_valid_i;
      if (in_valid_i) begin
        sq_q <= (2*IN_WIDTH)'(in_data_i) * (2*IN_WIDTH)'(in_data_i);
      end
    end
  end

  assign out_valid_o = sq_v_q;
  assign out_data_o  = sq_q;

endmodule

// File: rtl/vctr_sq_acc.sv
// Sum-of-squares reducer: pops vector_length elements from the upstream FIFO,
// squares and accumulates them, then holds the result on a valid/ack handshake.
module vctr_sq_acc
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LENGTH_BITS = 10,
  parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, LENGTH_BITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LENGTH_BITS-1:0] vector_length,
  output logic                   elem_rd_en,
  input  logic                   elem_empty,
  input  logic [DATA_WIDTH-1:0]  elem_data,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ack,
  output logic                   idle,
  output logic                   busy,
  output logic                   done
);

  sq_acc_state_t            state_q, state_d;
  logic [LENGTH_BITS-1:0]   len_q;
  logic [LENGTH_BITS-1:0]   issued_q;
  logic [LENGTH_BITS-1:0]   accum_q;
  logic                     rd_q;
  logic [ACC_WIDTH-1:0]     acc_q;
  logic                     sq_v;
  logic [2*DATA_WIDTH-1:0]  sq_data;
  logic                     start_ok;
  logic                     last_acc;

  // Handshake: acc_valid high means acc_out is final; it stays held until a
  // cycle with acc_ack high, after which the block returns to IDLE.
  assign start_ok   = (state_q == IDLE) && start;
  assign elem_rd_en = (state_q == ACCUM) && !elem_empty && (issued_q < len_q);
  assign last_acc   = sq_v && (({1'b0, accum_q} + 1'b1) == {1'b0, len_q});

  hsid_sq_stage #(
    .IN_WIDTH (DATA_WIDTH)
  ) u_sq (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rd_q),
    .in_data_i   (elem_data),
    .out_valid_o (sq_v),
    .out_data_o  (sq_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vector_length == '0) ? DONE : ACCUM;
      ACCUM:   if (last_acc) state_d = DONE;
      DONE:    if (acc_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      accum_q  <= '0;
      rd_q     <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= elem_rd_en;
      if (start_ok) begin
        len_q    <= vector_length;
        issued_q <= '0;
        accum_q  <= '0;
        acc_q    <= '0;
      end else begin
        if (elem_rd_en) issued_q <= issued_q + 1'b1;
        if (sq_v) begin
          acc_q   <= acc_q + ACC_WIDTH'(sq_data);
          accum_q <= accum_q + 1'b1;
        end
      end
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = (state_q == DONE);
  assign done      = (state_q == DONE);
  assign idle      = (state_q == IDLE);
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_vctr_sq_acc.sv
// Scoreboard bench for vctr_sq_acc with a behavioural upstream FIFO model.
module tb_vctr_sq_acc;
  localparam int DW = 16;
  localparam int LB = 10;
  localparam int AW = 2 * DW + LB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LB-1:0] vector_length;
  logic          elem_rd_en;
  logic          elem_empty;
  logic [DW-1:0] elem_data;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ack;
  logic          idle;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  vctr_sq_acc #(.DATA_WIDTH(DW), .LENGTH_BITS(LB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vector_length (vector_length),
    .elem_rd_en    (elem_rd_en),
    .elem_empty    (elem_empty),
    .elem_data     (elem_data),
    .acc_out       (acc_out),
    .acc_valid     (acc_valid),
    .acc_ack       (acc_ack),
    .idle          (idle),
    .busy          (busy),
    .done          (done)
  );

  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  int            checks;
  int            failures;
  int            pops;
  int            viol;
  bit            bubble_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Compares each newly presented result against the oldest expected one.
  task automatic monitor_loop();
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && acc_valid && !prev) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else chk("result", 64'(acc_out), 64'(exp_q.pop_front()));
      end
      prev = rst_n && acc_valid;
    end
  endtask

  // Upstream FIFO: read data appears the cycle after a pop; optional bubbles.
  task automatic fifo_loop();
    bit do_pop;
    bit ph = 1'b0;
    forever begin
      @(negedge clk);
      do_pop = elem_rd_en;
      if (elem_rd_en && (elem_empty || !busy)) viol++;
      @(posedge clk);
      #1;
      if (do_pop) begin
        pops++;
        if (fifo_q.size() > 0) elem_data = fifo_q.pop_front();
      end
      ph = ~ph;
      elem_empty = (fifo_q.size() == 0) || (bubble_en && ph);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acc_out"}, 64'(acc_out), 0);
    chk({tag, "_acc_valid"}, acc_valid, 0);
    chk({tag, "_rd_en"}, elem_rd_en, 0);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_reduction(input int len, input bit bub, input int hold, input bit poke);
    logic [63:0] e;
    int          lat;
    bit          got;
    bit          stable;
    e = 0;
    foreach (pend_q[i]) e = e + 64'(pend_q[i]) * 64'(pend_q[i]);
    fifo_q    = pend_q;
    bubble_en = bub;
    pops      = 0;
    viol      = 0;
    exp_q.push_back(AW'(e));
    @(negedge clk);
    start         = 1'b1;
    vector_length = LB'(len);
    @(posedge clk);
    #1;
    start         = 1'b0;
    vector_length = LB'($urandom);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 4000 && !got; c++) begin
      @(posedge clk);
      #1;
      if (acc_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("done_timeout", got, 1);
    if (!bub) chk("latency", lat, (len == 0) ? 1 : len + 2);
    stable = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (acc_out !== AW'(e) || !acc_valid || !done || busy || idle) stable = 1'b0;
      if (poke && c == 3) begin
        start         = 1'b1;
        vector_length = LB'(3);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (hold > 0) chk("hold_stable", stable, 1);
    @(negedge clk);
    acc_ack = 1'b1;
    @(posedge clk);
    #1;
    acc_ack = 1'b0;
    chk("ack_valid_low", acc_valid, 0);
    chk("ack_idle", idle, 1);
    chk("ack_keep_out", 64'(acc_out), e);
    repeat (3) @(negedge clk);
    chk("pop_count", pops, len);
    chk("no_bad_pop", viol, 0);
    chk("stays_idle", idle, 1);
  endtask

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    pops          = 0;
    viol          = 0;
    bubble_en     = 1'b0;
    rst_n         = 1'b0;
    start         = 1'b0;
    acc_ack       = 1'b0;
    vector_length = '0;
    elem_data     = '0;
    elem_empty    = 1'b1;
    fork
      monitor_loop();
      fifo_loop();
    join_none
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abandon a reduction after two pops with an asynchronous reset.
    fifo_q.delete();
    for (int i = 0; i < 5; i++) fifo_q.push_back(DW'($urandom));
    pops = 0;
    @(negedge clk);
    start         = 1'b1;
    vector_length = LB'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 50 && pops < 2; c++) @(negedge clk);
    chk("mid_pops", pops, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    fifo_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    pend_q = '{16'd7};
    run_reduction(1, 1'b0, 0, 1'b0);
    pend_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_reduction(4, 1'b0, 0, 1'b0);
    pend_q = '{16'hFFFF, 16'd2, 16'hFFFF};
    run_reduction(3, 1'b1, 0, 1'b0);
    pend_q.delete();
    run_reduction(0, 1'b0, 0, 1'b0);

    pend_q.delete();
    for (int i = 0; i < 5; i++) pend_q.push_back(DW'($urandom));
    run_reduction(5, 1'b0, 10, 1'b1);

    repeat (6) begin
      n = $urandom_range(1, 24);
      pend_q.delete();
      for (int i = 0; i < n; i++) pend_q.push_back(DW'($urandom));
      run_reduction(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    pend_q.delete();
    for (int i = 0; i < 1023; i++) pend_q.push_back(16'hFFFF);
    run_reduction(1023, 1'b0, 0, 1'b0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
